// File: rtl/disp_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller.
// Shows a 4-bit value as ones/tens digits, with a blanking gap between
// digit slots to prevent ghosting, and a one-cycle frame marker.
module disp_scan_ctrl #(
    parameter int unsigned REFRESH_CNT = 50000,
    parameter int unsigned BLANK_CNT   = 500,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] SW,
    output logic [6:0] AN,
    output logic       CA,
    output logic       FRAME
);

    localparam int unsigned MAX_CNT = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
    localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_CNT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CNT - 1);

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        GAP0  = 2'd1,
        SHOW1 = 2'd2,
        GAP1  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    val;

    logic          slot_done_c;
    logic          frame_start_c;
    state_t        next_state_c;
    state_t        disp_state_c;
    logic [3:0]    disp_val_c;
    logic [6:0]    ones_seg_c;
    logic [6:0]    tens_seg_c;

    // Decimal digit to active-high segment pattern (a = bit0 .. g = bit6).
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h27;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Ones digit of a 0..15 value.
    function automatic logic [3:0] ones_of(input logic [3:0] v);
        return (v >= 4'd10) ? 4'(v - 4'd10) : v;
    endfunction

    // Tens digit of a 0..15 value (only 0 or 1 possible).
    function automatic logic [3:0] tens_of(input logic [3:0] v);
        return (v >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    // Slot end detection, successor state and the value shown after this edge.
    always_comb begin
        slot_done_c   = 1'b0;
        next_state_c  = state;
        frame_start_c = 1'b0;

        case (state)
            SHOW0: begin
                slot_done_c  = (cnt == SHOW_LAST);
                next_state_c = GAP0;
            end
            GAP0: begin
                slot_done_c  = (cnt == GAP_LAST);
                next_state_c = SHOW1;
            end
            SHOW1: begin
                slot_done_c  = (cnt == SHOW_LAST);
                next_state_c = GAP1;
            end
            default: begin
                slot_done_c   = (cnt == GAP_LAST);
                next_state_c  = SHOW0;
                frame_start_c = (cnt == GAP_LAST);
            end
        endcase

        disp_state_c = slot_done_c ? next_state_c : state;
        // The frame's sample is taken on the same edge that starts SHOW0,
        // so the freshly sampled SW drives the ones digit with no extra delay.
        disp_val_c   = frame_start_c ? SW : val;
        ones_seg_c   = seg_of(ones_of(disp_val_c));
        tens_seg_c   = (LZ_BLANK && (tens_of(disp_val_c) == 4'd0))
                       ? 7'h00 : seg_of(tens_of(disp_val_c));
    end

    // Scan FSM, slot counter, frame sample and registered segment outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= GAP1;
            cnt   <= '0;
            val   <= 4'd0;
            AN    <= 7'h00;
            CA    <= 1'b0;
            FRAME <= 1'b0;
        end else if (!EN) begin
            AN    <= 7'h00;
            FRAME <= 1'b0;
        end else begin
            if (slot_done_c) begin
                state <= next_state_c;
                cnt   <= '0;
            end else begin
                cnt   <= cnt + CW'(1);
            end

            if (frame_start_c) begin
                val <= SW;
            end

            FRAME <= frame_start_c;

            case (disp_state_c)
                SHOW0: begin
                    AN <= ones_seg_c;
                    CA <= 1'b0;
                end
                SHOW1: begin
                    AN <= tens_seg_c;
                    CA <= 1'b1;
                end
                default: begin
                    AN <= 7'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a frame-position model checked every cycle on
// two instances (leading-zero blanking on and off) plus directed literals.
module tb_disp_scan_ctrl;

    localparam int R = 4;
    localparam int B = 1;
    localparam int P = 2 * (R + B);

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sw;
    logic [6:0] an1, an0;
    logic       ca1, ca0, fr1, fr0;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B), .LZ_BLANK(1'b1)) dut (
        .CLK(clk), .RST(rst), .EN(en), .SW(sw), .AN(an1), .CA(ca1), .FRAME(fr1)
    );

    disp_scan_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B), .LZ_BLANK(1'b0)) dut_nz (
        .CLK(clk), .RST(rst), .EN(en), .SW(sw), .AN(an0), .CA(ca0), .FRAME(fr0)
    );

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

    // Model: position within a frame of P enabled edges; 0..R-1 ones digit,
    // R..R+B-1 gap, R+B..2R+B-1 tens digit, rest gap.
    int         pos;
    int         mv;
    logic [6:0] m_an1, m_an0;
    logic       m_ca, m_fr;

    always @(posedge clk) begin
        if (rst) begin
            pos   = 2 * R + B;
            mv    = 0;
            m_an1 = 7'h00;
            m_an0 = 7'h00;
            m_ca  = 1'b0;
            m_fr  = 1'b0;
        end else if (!en) begin
            m_an1 = 7'h00;
            m_an0 = 7'h00;
            m_fr  = 1'b0;
        end else begin
            pos  = (pos + 1) % P;
            m_fr = (pos == 0);
            if (pos == 0) mv = int'(sw);
            if (pos < R) begin
                m_an1 = seg_tab[mv % 10];
                m_an0 = m_an1;
                m_ca  = 1'b0;
            end else if (pos < R + B) begin
                m_an1 = 7'h00;
                m_an0 = 7'h00;
            end else if (pos < 2 * R + B) begin
                m_an0 = seg_tab[mv / 10];
                m_an1 = (mv / 10 == 0) ? 7'h00 : seg_tab[mv / 10];
                m_ca  = 1'b1;
            end else begin
                m_an1 = 7'h00;
                m_an0 = 7'h00;
            end
        end
    end

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_an_lz",    an1,          m_an1);
            chk("model_ca_lz",    7'(ca1),      7'(m_ca));
            chk("model_frame_lz", 7'(fr1),      7'(m_fr));
            chk("model_an_nz",    an0,          m_an0);
            chk("model_ca_nz",    7'(ca0),      7'(m_ca));
            chk("model_frame_nz", 7'(fr0),      7'(m_fr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        sw  = 4'd7;
        tick(2);
        chk_on = 1'b1;
        chk("rst_an", an1, 7'h00);
        chk("rst_ca", 7'(ca1), 7'h0);
        chk("rst_frame", 7'(fr1), 7'h0);

        // Reset release, SW=7: frame immediately, ones=7, tens blank.
        rst = 1'b0;
        tick(1);
        chk("first_frame", 7'(fr1), 7'h1);
        chk("sw7_show0", an1, 7'h27);
        chk("sw7_ca0", 7'(ca1), 7'h0);
        tick(3);
        chk("sw7_show0_last", an1, 7'h27);
        tick(1);
        chk("sw7_gap0", an1, 7'h00);
        chk("sw7_gap0_ca", 7'(ca1), 7'h0);
        tick(1);
        chk("sw7_show1_lz", an1, 7'h00);
        chk("sw7_show1_ca", 7'(ca1), 7'h1);
        chk("sw7_show1_nz", an0, 7'h3F);
        tick(4);
        chk("sw7_gap1_frame", 7'(fr1), 7'h0);
        chk("sw7_gap1_ca", 7'(ca1), 7'h1);
        tick(1);
        chk("frame_period", 7'(fr1), 7'h1);

        // SW=13 then SW=15.
        sw = 4'd13;
        tick(10);
        chk("sw13_show0", an1, 7'h4F);
        tick(5);
        chk("sw13_show1", an1, 7'h06);
        sw = 4'd15;
        tick(5);
        chk("sw15_show0", an1, 7'h6D);
        tick(5);
        chk("sw15_show1", an1, 7'h06);

        // SW change mid-frame is deferred to the next frame.
        sw = 4'd13;
        tick(5);
        chk("mid_show0", an1, 7'h4F);
        tick(5);
        sw = 4'd2;
        tick(2);
        chk("mid_show1_hold", an1, 7'h06);
        tick(3);
        chk("sw2_show0", an1, 7'h5B);
        tick(5);
        chk("sw2_show1_lz", an1, 7'h00);
        chk("sw2_show1_nz", an0, 7'h3F);

        // Enable dropped at SHOW0 count 1 for 5 edges.
        tick(5);
        tick(1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_an", an1, 7'h00);
            chk("hold_ca", 7'(ca1), 7'h0);
            chk("hold_frame", 7'(fr1), 7'h0);
        end
        en = 1'b1;
        tick(1);
        chk("resume_an", an1, 7'h5B);
        tick(1);
        chk("resume_last", an1, 7'h5B);
        tick(1);
        chk("resume_gap0", an1, 7'h00);

        // Reset pulse inside SHOW1.
        tick(1);
        chk("pre_rst_ca", 7'(ca1), 7'h1);
        rst = 1'b1;
        tick(1);
        chk("midrst_an", an1, 7'h00);
        chk("midrst_ca", 7'(ca1), 7'h0);
        chk("midrst_frame", 7'(fr1), 7'h0);
        rst = 1'b0;
        tick(1);
        chk("postrst_frame", 7'(fr1), 7'h1);
        chk("postrst_an", an1, 7'h5B);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 400; i++) begin
            sw  = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst = 1'b0;
        en  = 1'b1;
        tick(2 * P);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
